// File: rtl/spi_master_calc_if.sv
// Host handshake and SPI pin bundle for the calculator-link SPI initiator.
// The master modport is the initiator's view; slave is the host/slave-side view.
interface spi_master_calc_if;
    logic       start;
    logic [7:0] x_in;
    logic [7:0] y_in;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       spi_cs_n;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_miso;

    modport master (
        input  start, x_in, y_in, spi_miso,
        output busy, done, result, spi_cs_n, spi_sclk, spi_mosi
    );

    modport slave (
        output start, x_in, y_in, spi_miso,
        input  busy, done, result, spi_cs_n, spi_sclk, spi_mosi
    );
endinterface

// File: rtl/spi_master_calc.sv
// SPI initiator (mode 0, MSB first) for the calculator link.
// One accepted start produces one CS-framed 24-bit transfer: X, Y, then a
// read-back byte whose MISO content becomes the result.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | CS high, waiting for start
// SETUP | CS low, SCLK low, first MOSI bit presented, CLK_DIV cycles
// SHIFT | 24 SCLK periods, CLK_DIV cycles low then CLK_DIV cycles high
// HOLD  | SCLK low, CS still low, CLK_DIV cycles before releasing CS
// GAP   | CS high, CLK_DIV cycles of deselect time, done pulses first cycle
module spi_master_calc #(
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_master_calc_if.master bus
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [4:0] LAST_BIT = 5'd23;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t           state, state_n;
    logic [DIV_W-1:0] div_cnt, div_n;
    logic [4:0]       bit_cnt, bit_n;
    logic [23:0]      tx_shift, tx_n;
    logic [7:0]       rx_shift, rx_n;
    logic             cs_n_q, cs_n_n;
    logic             sclk_q, sclk_n;
    logic             mosi_q, mosi_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;
    logic [7:0]       result_q, result_n;
    logic             div_tc;

    // Phase timer is a down-counter; terminal count marks the last cycle of a phase.
    assign div_tc = (div_cnt == '0);

    // State and all output registers; reset aborts any frame immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            cs_n_q   <= 1'b1;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state    <= state_n;
            div_cnt  <= div_n;
            bit_cnt  <= bit_n;
            tx_shift <= tx_n;
            rx_shift <= rx_n;
            cs_n_q   <= cs_n_n;
            sclk_q   <= sclk_n;
            mosi_q   <= mosi_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
            result_q <= result_n;
        end
    end

    // Next-state and next-output logic; every SPI pin comes straight from a flop.
    always_comb begin
        state_n  = state;
        div_n    = div_cnt;
        bit_n    = bit_cnt;
        tx_n     = tx_shift;
        rx_n     = rx_shift;
        cs_n_n   = cs_n_q;
        sclk_n   = sclk_q;
        mosi_n   = mosi_q;
        busy_n   = busy_q;
        done_n   = 1'b0;
        result_n = result_q;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    tx_n    = {bus.x_in, bus.y_in, 8'h00};
                    mosi_n  = bus.x_in[7];
                    rx_n    = '0;
                    bit_n   = '0;
                    div_n   = DIV_LOAD;
                    cs_n_n  = 1'b0;
                    sclk_n  = 1'b0;
                    busy_n  = 1'b1;
                    state_n = SETUP;
                end
            end

            SETUP: begin
                if (div_tc) begin
                    div_n   = DIV_LOAD;
                    state_n = SHIFT;
                end else begin
                    div_n = div_cnt - DIV_W'(1);
                end
            end

            SHIFT: begin
                if (!div_tc) begin
                    div_n = div_cnt - DIV_W'(1);
                end else begin
                    div_n = DIV_LOAD;
                    if (!sclk_q) begin
                        sclk_n = 1'b1;
                    end else begin
                        // Last cycle of the high phase: sample MISO, then drop
                        // SCLK and advance MOSI together on the falling edge.
                        rx_n   = {rx_shift[6:0], bus.spi_miso};
                        sclk_n = 1'b0;
                        tx_n   = {tx_shift[22:0], 1'b0};
                        mosi_n = tx_shift[22];
                        if (bit_cnt == LAST_BIT) begin
                            state_n = HOLD;
                        end else begin
                            bit_n = bit_cnt + 5'd1;
                        end
                    end
                end
            end

            HOLD: begin
                if (div_tc) begin
                    // Only the last eight sampled bits (byte 3) survive in rx_shift.
                    div_n    = DIV_LOAD;
                    cs_n_n   = 1'b1;
                    done_n   = 1'b1;
                    result_n = rx_shift;
                    state_n  = GAP;
                end else begin
                    div_n = div_cnt - DIV_W'(1);
                end
            end

            GAP: begin
                if (div_tc) begin
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    div_n = div_cnt - DIV_W'(1);
                end
            end

            default: begin
                state_n = IDLE;
                cs_n_n  = 1'b1;
                sclk_n  = 1'b0;
                busy_n  = 1'b0;
            end
        endcase
    end

    assign bus.spi_cs_n = cs_n_q;
    assign bus.spi_sclk = sclk_q;
    assign bus.spi_mosi = mosi_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;

endmodule

// File: tb/tb_spi_master_calc.sv
// Bench for spi_master_calc: two instances (CLK_DIV=4 and CLK_DIV=1) with a
// behavioural mode-0 slave each; expected frames are queued at start time and
// compared when the DUT reports done.
module tb_spi_master_calc;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_master_calc_if bus4();
    spi_master_calc_if bus1();

    spi_master_calc #(.CLK_DIV(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.master));
    spi_master_calc #(.CLK_DIV(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.master));

    logic [1:0] start_v = '0;
    logic [7:0] x_v [2];
    logic [7:0] y_v [2];
    logic [1:0] miso_v = '0;
    logic [23:0] resp_v [2];

    assign bus4.start    = start_v[0];
    assign bus4.x_in     = x_v[0];
    assign bus4.y_in     = y_v[0];
    assign bus4.spi_miso = miso_v[0];
    assign bus1.start    = start_v[1];
    assign bus1.x_in     = x_v[1];
    assign bus1.y_in     = y_v[1];
    assign bus1.spi_miso = miso_v[1];

    logic [1:0] cs_a, sclk_a, mosi_a, busy_a, done_a;
    logic [7:0] res_a [2];
    assign cs_a[0] = bus4.spi_cs_n;  assign cs_a[1] = bus1.spi_cs_n;
    assign sclk_a[0] = bus4.spi_sclk; assign sclk_a[1] = bus1.spi_sclk;
    assign mosi_a[0] = bus4.spi_mosi; assign mosi_a[1] = bus1.spi_mosi;
    assign busy_a[0] = bus4.busy;    assign busy_a[1] = bus1.busy;
    assign done_a[0] = bus4.done;    assign done_a[1] = bus1.done;
    assign res_a[0]  = bus4.result;  assign res_a[1]  = bus1.result;

    typedef struct { logic [7:0] x; logic [7:0] y; logic [7:0] r; } exp_t;
    typedef struct { logic [23:0] w; int rises; int low; } obs_t;

    exp_t exp_q[$];
    obs_t obs_q[$];
    int   gap_q[$];

    int n_pass  = 0;
    int n_total = 0;

    function automatic int divof(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    // Slave + bus monitor state, one slot per instance
    logic [1:0]  prev_cs   = 2'b11;
    logic [1:0]  prev_sclk = 2'b00;
    int          low_cnt [2];
    int          rises   [2];
    int          hi_cnt  [2];
    int          bitn    [2];
    int          phase_len [2];
    int          phase_err [2];
    logic [23:0] mword   [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            low_cnt[i] = 0; rises[i] = 0; hi_cnt[i] = 0; bitn[i] = 0;
            phase_len[i] = 0; phase_err[i] = 0; mword[i] = '0;
            x_v[i] = '0; y_v[i] = '0; resp_v[i] = '0;
        end
    end

    // Mode-0 slave: captures MOSI on SCLK rise, updates MISO after SCLK fall;
    // also records frame length, rising-edge count, CS-high gaps and SCLK phases.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!cs_a[i]) begin
                if (prev_cs[i]) begin
                    gap_q.push_back(hi_cnt[i]);
                    low_cnt[i] = 1; rises[i] = 0; mword[i] = '0; bitn[i] = 0;
                    phase_len[i] = 1;
                    miso_v[i] = resp_v[i][23];
                end else begin
                    low_cnt[i]++;
                    if (sclk_a[i] && !prev_sclk[i]) begin
                        rises[i]++;
                        mword[i] = {mword[i][22:0], mosi_a[i]};
                        if (rises[i] > 1)
                            assert (phase_len[i] == divof(i)) else phase_err[i]++;
                        phase_len[i] = 1;
                    end else if (!sclk_a[i] && prev_sclk[i]) begin
                        assert (phase_len[i] == divof(i)) else phase_err[i]++;
                        phase_len[i] = 1;
                        bitn[i]++;
                        miso_v[i] = (bitn[i] < 24) ? resp_v[i][23 - bitn[i]] : 1'b0;
                    end else begin
                        phase_len[i]++;
                    end
                end
            end else begin
                if (!prev_cs[i]) begin
                    obs_q.push_back('{w: mword[i], rises: rises[i], low: low_cnt[i]});
                    hi_cnt[i] = 1;
                end else begin
                    hi_cnt[i]++;
                end
                miso_v[i] = 1'b0;
            end
            prev_cs[i]   = cs_a[i];
            prev_sclk[i] = sclk_a[i];
        end
    end

    task automatic wait_idle(input int i);
        int k = 0;
        while (busy_a[i] && k < 200) begin
            @(posedge clk); #1; k++;
        end
        n_total++;
        if (busy_a[i] !== 1'b0) $display("FAIL idle_timeout inst=%0d busy=%b want 0", i, busy_a[i]);
        else n_pass++;
    endtask

    // Pop one expected/observed pair and compare result and bus framing
    task automatic check_frame(input int i);
        exp_t e;
        obs_t o;
        n_total++;
        if (exp_q.size() == 0 || obs_q.size() == 0) begin
            $display("FAIL frame_missing inst=%0d exp=%0d obs=%0d want >=1 each", i, exp_q.size(), obs_q.size());
            return;
        end
        n_pass++;
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        n_total++;
        if (o.w !== {e.x, e.y, 8'h00}) $display("FAIL mosi_bytes inst=%0d got %h want %h", i, o.w, {e.x, e.y, 8'h00});
        else n_pass++;
        n_total++;
        if (o.rises !== 24) $display("FAIL sclk_rises inst=%0d got %0d want 24", i, o.rises);
        else n_pass++;
        n_total++;
        if (o.low !== 50 * divof(i)) $display("FAIL cs_low_len inst=%0d got %0d want %0d", i, o.low, 50 * divof(i));
        else n_pass++;
    endtask

    // One start pulse, wait for done; optionally poke start and operands mid-frame
    task automatic run_frame(input int i, input logic [7:0] x, input logic [7:0] y,
                             input logic [7:0] r, input logic [7:0] fill, input bit disturb);
        int lat;
        exp_t e;
        resp_v[i] = {fill, fill, r};
        @(posedge clk); #1;
        start_v[i] = 1'b1; x_v[i] = x; y_v[i] = y;
        e.x = x; e.y = y; e.r = r;
        exp_q.push_back(e);
        @(posedge clk); #1;
        start_v[i] = 1'b0;
        lat = 0;
        while (!done_a[i] && lat < 2000) begin
            if (disturb && lat == 50) begin
                start_v[i] = 1'b1; x_v[i] = ~x; y_v[i] = ~y;
            end else if (disturb && lat == 51) begin
                start_v[i] = 1'b0;
            end
            @(posedge clk); #1; lat++;
        end
        n_total++;
        if (lat !== 50 * divof(i)) $display("FAIL done_latency inst=%0d got %0d want %0d", i, lat, 50 * divof(i));
        else n_pass++;
        n_total++;
        if (res_a[i] !== r) $display("FAIL result inst=%0d got %h want %h", i, res_a[i], r);
        else n_pass++;
        wait_idle(i);
        check_frame(i);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        for (int i = 0; i < 2; i++) begin
            n_total++;
            if ({cs_a[i], sclk_a[i], mosi_a[i], busy_a[i], done_a[i]} !== 5'b10000)
                $display("FAIL reset_pins inst=%0d got cs,sclk,mosi,busy,done=%b want 10000", i,
                         {cs_a[i], sclk_a[i], mosi_a[i], busy_a[i], done_a[i]});
            else n_pass++;
            n_total++;
            if (res_a[i] !== 8'h00) $display("FAIL reset_result inst=%0d got %h want 00", i, res_a[i]);
            else n_pass++;
        end
        #5 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        run_frame(0, 8'h12, 8'h34, 8'h46, 8'h00, 1'b0);
    endtask

    task automatic test_results();
        run_frame(0, 8'hC3, 8'h5A, 8'hFF, 8'hFF, 1'b0);
        run_frame(0, 8'h81, 8'h7E, 8'h00, 8'hFF, 1'b0);
        run_frame(0, 8'h0F, 8'hF0, 8'hA5, 8'hFF, 1'b0);
    endtask

    task automatic test_busy_ignore();
        run_frame(0, 8'h96, 8'h69, 8'h3C, 8'h55, 1'b1);
        repeat (30) @(posedge clk);
        #1;
        n_total++;
        if (busy_a[0] !== 1'b0 || cs_a[0] !== 1'b1 || obs_q.size() != 0)
            $display("FAIL no_extra_frame busy=%b cs_n=%b frames=%0d want 0 1 0", busy_a[0], cs_a[0], obs_q.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        int k = 0;
        exp_t e;
        gap_q.delete();
        resp_v[0] = {8'h00, 8'h00, 8'h5A};
        e.x = 8'hAB; e.y = 8'hCD; e.r = 8'h5A;
        @(posedge clk); #1;
        x_v[0] = e.x; y_v[0] = e.y; start_v[0] = 1'b1;
        for (int j = 0; j < 3; j++) exp_q.push_back(e);
        while (dones < 3 && k < 3000) begin
            @(posedge clk); #1; k++;
            if (done_a[0]) begin
                dones++;
                n_total++;
                if (res_a[0] !== 8'h5A) $display("FAIL b2b_result frame=%0d got %h want 5a", dones, res_a[0]);
                else n_pass++;
                if (dones == 3) start_v[0] = 1'b0;
            end
        end
        start_v[0] = 1'b0;
        n_total++;
        if (dones !== 3) $display("FAIL b2b_done_count got %0d want 3", dones);
        else n_pass++;
        wait_idle(0);
        for (int j = 0; j < 3; j++) check_frame(0);
        n_total++;
        if (gap_q.size() != 3) $display("FAIL b2b_gap_count got %0d want 3", gap_q.size());
        else begin
            n_pass++;
            for (int j = 1; j < 3; j++) begin
                n_total++;
                if (gap_q[j] !== 5) $display("FAIL b2b_gap_len idx=%0d got %0d want 5", j, gap_q[j]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_abort();
        resp_v[0] = {8'h00, 8'h00, 8'h77};
        @(posedge clk); #1;
        x_v[0] = 8'hEE; y_v[0] = 8'hDD; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (86) @(posedge clk);
        #1;
        n_total++;
        if (busy_a[0] !== 1'b1 || rises[0] !== 10)
            $display("FAIL abort_setup busy=%b rises=%0d want 1 10", busy_a[0], rises[0]);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({cs_a[0], sclk_a[0], busy_a[0], done_a[0]} !== 4'b1000)
            $display("FAIL abort_pins got cs,sclk,busy,done=%b want 1000", {cs_a[0], sclk_a[0], busy_a[0], done_a[0]});
        else n_pass++;
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk); #1;
        obs_q.delete();
        exp_q.delete();
        run_frame(0, 8'h01, 8'h02, 8'h3C, 8'h00, 1'b0);
    endtask

    task automatic test_div1();
        run_frame(1, 8'h9A, 8'hBC, 8'hD2, 8'h33, 1'b0);
        run_frame(1, 8'hFF, 8'h00, 8'h81, 8'h00, 1'b0);
        for (int i = 0; i < 2; i++) begin
            n_total++;
            if (phase_err[i] !== 0) $display("FAIL sclk_phase inst=%0d errors=%0d want 0", i, phase_err[i]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_results();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        test_div1();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
